// File: rtl/riscv_wb_pkg.sv
// Shared types for the write-back stage: W2 source encoding and write request layout.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package riscv_wb_pkg;

    // W2 sources; the round-robin pointer holds the source that wins the next contended cycle.
    typedef enum logic {
        WB_LSU = 1'b0,
        WB_MDU = 1'b1
    } wb_src_e;

    // Default geometry of the integer/FP register file.
    localparam int WB_ADDR_WIDTH = 6;
    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_FPU        = 0;

    // Scoreboard depth for the default geometry.
    // Without an FP bank the upper address bit aliases onto the integer file (Zfinx).
    localparam int NUM_SB_REGS = (WB_FPU != 0) ? (2 ** WB_ADDR_WIDTH) : 32;

    // One write request as seen by a regfile write port.
    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] waddr;
        logic [WB_DATA_WIDTH-1:0] wdata;
    } wb_req_t;

    // Scoreboard depth for an arbitrary instance geometry.
    function automatic int sb_regs(input int fpu, input int addr_width);
        return (fpu != 0) ? (1 << addr_width) : 32;
    endfunction

endpackage

// File: rtl/riscv_wb_rr_arbiter.sv
// Two-input round-robin grant between LSU and MDU results for regfile port W2.
// Latency: grant is combinational in the request cycle; only the pointer is registered.
// Backpressure: the source without a grant sees ready low and must hold its request.
module riscv_wb_rr_arbiter
    import riscv_wb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_lsu,
    input  logic req_mdu,
    output logic gnt_lsu,
    output logic gnt_mdu
);

    wb_src_e ptr;

    // A lone requester always wins; on contention the pointer decides.
    always_comb begin
        gnt_lsu = req_lsu && (!req_mdu || (ptr == WB_LSU));
        gnt_mdu = req_mdu && (!req_lsu || (ptr == WB_MDU));
    end

    // Hand priority to the loser after every contended grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= WB_LSU;
        end else if (req_lsu && req_mdu) begin
            ptr <= (ptr == WB_LSU) ? WB_MDU : WB_LSU;
        end
    end

endmodule

// File: rtl/riscv_wb_scoreboard.sv
// Write-back stage: ALU to W1, LSU/MDU round-robin to W2, busy scoreboard and RAW hazard flags for ID.
// Latency: one registered cycle from result valid to regfile write; hazards and read data are combinational.
// Backpressure: ALU always accepted; LSU/MDU ready equals grant; issue_full_o stops ID issuing.
// Optional forwarding from the staged W1/W2 writes is enabled by defining RISCV_WB_BYPASS_EN.
module riscv_wb_scoreboard
    import riscv_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int FPU        = 0,
    parameter int CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid_i,
    input  logic [ADDR_WIDTH-1:0] alu_waddr_i,
    input  logic [DATA_WIDTH-1:0] alu_wdata_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    input  logic                  mdu_valid_i,
    output logic                  mdu_ready_o,
    input  logic [ADDR_WIDTH-1:0] mdu_waddr_i,
    input  logic [DATA_WIDTH-1:0] mdu_wdata_i,
    input  logic                  issue_valid_i,
    input  logic [ADDR_WIDTH-1:0] issue_waddr_i,
    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    input  logic [ADDR_WIDTH-1:0] raddr_c_i,
    input  logic [DATA_WIDTH-1:0] rf_rdata_a_i,
    input  logic [DATA_WIDTH-1:0] rf_rdata_b_i,
    input  logic [DATA_WIDTH-1:0] rf_rdata_c_i,
    output logic [DATA_WIDTH-1:0] rdata_a_o,
    output logic [DATA_WIDTH-1:0] rdata_b_o,
    output logic [DATA_WIDTH-1:0] rdata_c_o,
    output logic                  hazard_a_o,
    output logic                  hazard_b_o,
    output logic                  hazard_c_o,
    output logic                  issue_full_o,
    output logic                  we_a_o,
    output logic [ADDR_WIDTH-1:0] waddr_a_o,
    output logic [DATA_WIDTH-1:0] wdata_a_o,
    output logic                  we_b_o,
    output logic [ADDR_WIDTH-1:0] waddr_b_o,
    output logic [DATA_WIDTH-1:0] wdata_b_o
);

    localparam int SB_REGS = sb_regs(FPU, ADDR_WIDTH);
    localparam int SB_AW   = $clog2(SB_REGS);

    logic                  gnt_lsu;
    logic                  gnt_mdu;
    logic [ADDR_WIDTH-1:0] w2_waddr;
    logic [DATA_WIDTH-1:0] w2_wdata;
    logic [SB_REGS-1:0]    busy;
    logic [CNT_W-1:0]      count;
    logic                  issue_take;
    logic                  count_inc;
    logic                  count_dec;
    logic [SB_AW-1:0]      issue_idx;
    logic [SB_AW-1:0]      commit_idx;

    logic [ADDR_WIDTH-1:0] rd_addr [3];
    logic [DATA_WIDTH-1:0] rd_rf   [3];
    logic [DATA_WIDTH-1:0] rd_out  [3];
    logic [2:0]            rd_nz;
    logic [2:0]            rd_busy;
    logic [2:0]            rd_w1_hit;
    logic [2:0]            rd_haz;

    riscv_wb_rr_arbiter u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_lsu (lsu_valid_i),
        .req_mdu (mdu_valid_i),
        .gnt_lsu (gnt_lsu),
        .gnt_mdu (gnt_mdu)
    );

    assign lsu_ready_o = gnt_lsu;
    assign mdu_ready_o = gnt_mdu;
    assign w2_waddr    = gnt_lsu ? lsu_waddr_i : mdu_waddr_i;
    assign w2_wdata    = gnt_lsu ? lsu_wdata_i : mdu_wdata_i;

    // W1 stage: ALU results land one cycle later; x0 never raises a write enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_a_o    <= 1'b0;
            waddr_a_o <= '0;
            wdata_a_o <= '0;
        end else begin
            we_a_o <= alu_valid_i && (alu_waddr_i != '0);
            if (alu_valid_i) begin
                waddr_a_o <= alu_waddr_i;
                wdata_a_o <= alu_wdata_i;
            end
        end
    end

    // W2 stage: the granted LSU/MDU result lands one cycle later; x0 never raises a write enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_b_o    <= 1'b0;
            waddr_b_o <= '0;
            wdata_b_o <= '0;
        end else begin
            we_b_o <= (gnt_lsu || gnt_mdu) && (w2_waddr != '0);
            if (gnt_lsu || gnt_mdu) begin
                waddr_b_o <= w2_waddr;
                wdata_b_o <= w2_wdata;
            end
        end
    end

    // An issue is dropped while full or when it targets x0, so x0 never owns a busy bit or a count slot.
    assign issue_full_o = (count == {CNT_W{1'b1}});
    assign issue_take   = issue_valid_i && !issue_full_o;
    assign count_inc    = issue_take && (issue_waddr_i != '0);
    assign count_dec    = we_b_o && (count != '0);
    assign issue_idx    = issue_waddr_i[SB_AW-1:0];
    assign commit_idx   = waddr_b_o[SB_AW-1:0];

    // Busy bits: a new reservation beats a commit to the same register in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            for (int r = 0; r < SB_REGS; r++) begin
                if (count_inc && (issue_idx == SB_AW'(r))) begin
                    busy[r] <= 1'b1;
                end else if (we_b_o && (commit_idx == SB_AW'(r))) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    // Outstanding long-op counter; issue and commit together leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (count_inc && !count_dec) begin
            count <= count + 1'b1;
        end else if (count_dec && !count_inc) begin
            count <= count - 1'b1;
        end
    end

    assign rd_addr[0] = raddr_a_i;
    assign rd_addr[1] = raddr_b_i;
    assign rd_addr[2] = raddr_c_i;
    assign rd_rf[0]   = rf_rdata_a_i;
    assign rd_rf[1]   = rf_rdata_b_i;
    assign rd_rf[2]   = rf_rdata_c_i;

    // Per read port: nonzero address, pending busy bit, and match against the staged W1 write.
    always_comb begin
        rd_nz     = '0;
        rd_busy   = '0;
        rd_w1_hit = '0;
        for (int i = 0; i < 3; i++) begin
            rd_nz[i]     = (rd_addr[i] != '0);
            rd_busy[i]   = busy[rd_addr[i][SB_AW-1:0]];
            rd_w1_hit[i] = we_a_o && (waddr_a_o == rd_addr[i]);
        end
    end

`ifdef RISCV_WB_BYPASS_EN
    logic [2:0] rd_w2_hit;

    // Forward staged W2 first (it wins in the regfile too), then W1; a committing register is not a hazard.
    always_comb begin
        rd_w2_hit = '0;
        rd_haz    = '0;
        for (int i = 0; i < 3; i++) begin
            rd_w2_hit[i] = we_b_o && (waddr_b_o == rd_addr[i]);
            rd_out[i]    = rd_w2_hit[i] ? wdata_b_o :
                           rd_w1_hit[i] ? wdata_a_o : rd_rf[i];
            rd_haz[i]    = rd_nz[i] && rd_busy[i] && !rd_w2_hit[i];
        end
    end
`else
    // No forwarding: staged writes are not yet readable, so they stall ID for a cycle.
    always_comb begin
        rd_haz = '0;
        for (int i = 0; i < 3; i++) begin
            rd_out[i] = rd_rf[i];
            rd_haz[i] = rd_nz[i] && (rd_busy[i] || rd_w1_hit[i]);
        end
    end
`endif

    assign rdata_a_o  = rd_out[0];
    assign rdata_b_o  = rd_out[1];
    assign rdata_c_o  = rd_out[2];
    assign hazard_a_o = rd_haz[0];
    assign hazard_b_o = rd_haz[1];
    assign hazard_c_o = rd_haz[2];

    // ID must respect issue_full_o; an issue while full would lose its reservation.
    issue_while_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(issue_valid_i && issue_full_o));

endmodule

// File: tb/tb_riscv_wb_scoreboard.sv
// Self-checking bench for riscv_wb_scoreboard (FP bank present, 4-bit outstanding counter).
// Expected W1/W2 writes are queued when stimulus is driven and popped when the DUT writes.
// Directed sequences cover reset, hazards, arbitration, set/clear collision, x0 and saturation.
module tb_riscv_wb_scoreboard;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid;
    logic [AW-1:0] alu_waddr;
    logic [DW-1:0] alu_wdata;
    logic          lsu_valid;
    logic          lsu_ready;
    logic [AW-1:0] lsu_waddr;
    logic [DW-1:0] lsu_wdata;
    logic          mdu_valid;
    logic          mdu_ready;
    logic [AW-1:0] mdu_waddr;
    logic [DW-1:0] mdu_wdata;
    logic          issue_valid;
    logic [AW-1:0] issue_waddr;
    logic [AW-1:0] raddr_a, raddr_b, raddr_c;
    logic [DW-1:0] rf_rdata_a, rf_rdata_b, rf_rdata_c;
    logic [DW-1:0] rdata_a, rdata_b, rdata_c;
    logic          hazard_a, hazard_b, hazard_c;
    logic          issue_full;
    logic          we_a, we_b;
    logic [AW-1:0] waddr_a, waddr_b;
    logic [DW-1:0] wdata_a, wdata_b;

    int n_vec = 0;
    int n_err = 0;
    logic [AW+DW-1:0] exp_w1[$];
    logic [AW+DW-1:0] exp_w2[$];

    always #5 clk = ~clk;

    riscv_wb_scoreboard #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FPU        (1),
        .CNT_W      (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_valid_i   (alu_valid),
        .alu_waddr_i   (alu_waddr),
        .alu_wdata_i   (alu_wdata),
        .lsu_valid_i   (lsu_valid),
        .lsu_ready_o   (lsu_ready),
        .lsu_waddr_i   (lsu_waddr),
        .lsu_wdata_i   (lsu_wdata),
        .mdu_valid_i   (mdu_valid),
        .mdu_ready_o   (mdu_ready),
        .mdu_waddr_i   (mdu_waddr),
        .mdu_wdata_i   (mdu_wdata),
        .issue_valid_i (issue_valid),
        .issue_waddr_i (issue_waddr),
        .raddr_a_i     (raddr_a),
        .raddr_b_i     (raddr_b),
        .raddr_c_i     (raddr_c),
        .rf_rdata_a_i  (rf_rdata_a),
        .rf_rdata_b_i  (rf_rdata_b),
        .rf_rdata_c_i  (rf_rdata_c),
        .rdata_a_o     (rdata_a),
        .rdata_b_o     (rdata_b),
        .rdata_c_o     (rdata_c),
        .hazard_a_o    (hazard_a),
        .hazard_b_o    (hazard_b),
        .hazard_c_o    (hazard_c),
        .issue_full_o  (issue_full),
        .we_a_o        (we_a),
        .waddr_a_o     (waddr_a),
        .wdata_a_o     (wdata_a),
        .we_b_o        (we_b),
        .waddr_b_o     (waddr_b),
        .wdata_b_o     (wdata_b)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write monitor: every regfile write must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (we_a === 1'b1) begin
                if (exp_w1.size() == 0) check_val("w1_unexpected_we", 64'(we_a), 64'd0);
                else check_val("w1_write", 64'({waddr_a, wdata_a}), 64'(exp_w1.pop_front()));
            end
            if (we_b === 1'b1) begin
                if (exp_w2.size() == 0) check_val("w2_unexpected_we", 64'(we_b), 64'd0);
                else check_val("w2_write", 64'({waddr_b, wdata_b}), 64'(exp_w2.pop_front()));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        alu_valid = 0; alu_waddr = '0; alu_wdata = '0;
        lsu_valid = 0; lsu_waddr = '0; lsu_wdata = '0;
        mdu_valid = 0; mdu_waddr = '0; mdu_wdata = '0;
        issue_valid = 0; issue_waddr = '0;
        raddr_a = '0; raddr_b = '0; raddr_c = '0;
        rf_rdata_a = 32'h1111_1111; rf_rdata_b = 32'h2222_2222; rf_rdata_c = 32'h3333_3333;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_we_a", 64'(we_a), 64'd0);
        check_val("rst_we_b", 64'(we_b), 64'd0);
        check_val("rst_waddr_a", 64'(waddr_a), 64'd0);
        check_val("rst_wdata_b", 64'(wdata_b), 64'd0);
        check_val("rst_ready", 64'({lsu_ready, mdu_ready}), 64'd0);
        check_val("rst_hazards", 64'({hazard_a, hazard_b, hazard_c}), 64'd0);
        check_val("rst_full", 64'(issue_full), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Reset in the middle of staged ALU and LSU writes
        issue_valid = 1; issue_waddr = 6'd3; tick(); issue_valid = 0;
        raddr_a = 6'd3;
        alu_valid = 1; alu_waddr = 6'd4; alu_wdata = 32'hA000_0004;
        lsu_valid = 1; lsu_waddr = 6'd3; lsu_wdata = 32'hB000_0003;
        @(negedge clk);
        check_val("mid_hazard_a", 64'(hazard_a), 64'd1);
        check_val("mid_lsu_ready", 64'(lsu_ready), 64'd1);
        @(posedge clk); #2 rst_n = 1'b0; alu_valid = 0; lsu_valid = 0;
        @(negedge clk);
        check_val("mid_rst_we", 64'({we_a, we_b}), 64'd0);
        check_val("mid_rst_hazard_a", 64'(hazard_a), 64'd0);
        check_val("mid_rst_full", 64'(issue_full), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_hazard_a", 64'(hazard_a), 64'd0);
        tick();

        // Load to x5: hazard while pending, released by the W2 commit
        issue_valid = 1; issue_waddr = 6'd5; tick(); issue_valid = 0;
        raddr_a = 6'd5;
        @(negedge clk);
        check_val("ld_hazard_a", 64'(hazard_a), 64'd1);
        check_val("ld_rdata_a", 64'(rdata_a), 64'h1111_1111);
        tick();
        lsu_valid = 1; lsu_waddr = 6'd5; lsu_wdata = 32'hDEAD_BEEF;
        exp_w2.push_back({6'd5, 32'hDEAD_BEEF});
        @(negedge clk);
        check_val("ld_lsu_ready", 64'(lsu_ready), 64'd1);
        check_val("ld_hazard_resp", 64'(hazard_a), 64'd1);
        tick(); lsu_valid = 0;
        @(negedge clk);
`ifdef RISCV_WB_BYPASS_EN
        check_val("ld_commit_hazard", 64'(hazard_a), 64'd0);
        check_val("ld_commit_rdata", 64'(rdata_a), 64'hDEAD_BEEF);
`else
        check_val("ld_commit_hazard", 64'(hazard_a), 64'd1);
        check_val("ld_commit_rdata", 64'(rdata_a), 64'h1111_1111);
`endif
        tick();
        @(negedge clk);
        check_val("ld_done_hazard", 64'(hazard_a), 64'd0);
        tick();

        // ALU write to x9 staged in W1 while ID reads x9
        alu_valid = 1; alu_waddr = 6'd9; alu_wdata = 32'hCAFE_0009;
        exp_w1.push_back({6'd9, 32'hCAFE_0009});
        tick(); alu_valid = 0; raddr_b = 6'd9;
        @(negedge clk);
`ifdef RISCV_WB_BYPASS_EN
        check_val("w1_stage_hazard_b", 64'(hazard_b), 64'd0);
        check_val("w1_stage_rdata_b", 64'(rdata_b), 64'hCAFE_0009);
`else
        check_val("w1_stage_hazard_b", 64'(hazard_b), 64'd1);
        check_val("w1_stage_rdata_b", 64'(rdata_b), 64'h2222_2222);
`endif
        tick();
        @(negedge clk);
        check_val("w1_done_hazard_b", 64'(hazard_b), 64'd0);
        tick();

        // Continuous LSU/MDU contention: grants LSU, MDU, LSU, then the held MDU result
        for (int r = 10; r < 14; r++) begin
            issue_valid = 1; issue_waddr = AW'(r); tick();
        end
        issue_valid = 0;
        lsu_valid = 1; lsu_waddr = 6'd10; lsu_wdata = 32'h4C00_0001;
        mdu_valid = 1; mdu_waddr = 6'd12; mdu_wdata = 32'h4D00_0001;
        @(negedge clk);
        check_val("rr1_ready", 64'({lsu_ready, mdu_ready}), 64'b10);
        exp_w2.push_back({6'd10, 32'h4C00_0001});
        tick();
        lsu_waddr = 6'd11; lsu_wdata = 32'h4C00_0002;
        @(negedge clk);
        check_val("rr2_ready", 64'({lsu_ready, mdu_ready}), 64'b01);
        exp_w2.push_back({6'd12, 32'h4D00_0001});
        tick();
        mdu_waddr = 6'd13; mdu_wdata = 32'h4D00_0002;
        @(negedge clk);
        check_val("rr3_ready", 64'({lsu_ready, mdu_ready}), 64'b10);
        exp_w2.push_back({6'd11, 32'h4C00_0002});
        tick();
        lsu_valid = 0;
        @(negedge clk);
        check_val("rr4_ready", 64'({lsu_ready, mdu_ready}), 64'b01);
        exp_w2.push_back({6'd13, 32'h4D00_0002});
        tick(); mdu_valid = 0;

        // Re-issue to x7 in the cycle its previous load commits: busy stays set
        issue_valid = 1; issue_waddr = 6'd7; tick(); issue_valid = 0;
        lsu_valid = 1; lsu_waddr = 6'd7; lsu_wdata = 32'h7777_0001;
        exp_w2.push_back({6'd7, 32'h7777_0001});
        tick(); lsu_valid = 0;
        issue_valid = 1; issue_waddr = 6'd7;
        tick(); issue_valid = 0; raddr_c = 6'd7;
        @(negedge clk);
        check_val("setclr_hazard_c", 64'(hazard_c), 64'd1);
        tick();
        lsu_valid = 1; lsu_waddr = 6'd7; lsu_wdata = 32'h7777_0002;
        exp_w2.push_back({6'd7, 32'h7777_0002});
        tick(); lsu_valid = 0;
        tick();
        @(negedge clk);
        check_val("setclr_done_hazard_c", 64'(hazard_c), 64'd0);
        tick();

        // Writes and issue to x0 are all no-ops
        issue_valid = 1; issue_waddr = 6'd0; raddr_a = 6'd0;
        alu_valid = 1; alu_waddr = 6'd0; alu_wdata = 32'h0000_0001;
        lsu_valid = 1; lsu_waddr = 6'd0; lsu_wdata = 32'h0000_0002;
        @(negedge clk);
        check_val("x0_lsu_ready", 64'(lsu_ready), 64'd1);
        tick();
        issue_valid = 0; alu_valid = 0; lsu_valid = 0;
        @(negedge clk);
        check_val("x0_we", 64'({we_a, we_b}), 64'd0);
        check_val("x0_hazard_a", 64'(hazard_a), 64'd0);
        tick();

        // FP register 33 plus fourteen more issues saturate the counter
        issue_valid = 1; issue_waddr = 6'd33; tick();
        for (int r = 40; r < 53; r++) begin
            issue_waddr = AW'(r); tick();
        end
        issue_valid = 0;
        @(negedge clk);
        check_val("sat_full_at_14", 64'(issue_full), 64'd0);
        tick();
        issue_valid = 1; issue_waddr = 6'd53; tick(); issue_valid = 0;
        raddr_a = 6'd33; raddr_b = 6'd1; raddr_c = 6'd34;
        @(negedge clk);
        check_val("sat_full_at_15", 64'(issue_full), 64'd1);
        check_val("sat_hazards", 64'({hazard_a, hazard_b, hazard_c}), 64'b100);
        tick();
        mdu_valid = 1; mdu_waddr = 6'd40; mdu_wdata = 32'h0F00_0040;
        exp_w2.push_back({6'd40, 32'h0F00_0040});
        @(negedge clk);
        check_val("sat_mdu_ready", 64'(mdu_ready), 64'd1);
        tick(); mdu_valid = 0;
        @(negedge clk);
        check_val("sat_full_commit_cycle", 64'(issue_full), 64'd1);
        tick();
        @(negedge clk);
        check_val("sat_full_after_commit", 64'(issue_full), 64'd0);
        tick();
        repeat (2) tick();

        check_val("w1_queue_drained", 64'(exp_w1.size()), 64'd0);
        check_val("w2_queue_drained", 64'(exp_w2.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
